// File: rtl/eth_tx_frame.sv
// eth_tx_frame
// GMII-side Ethernet transmit framer. Takes a frame byte stream (DA, SA,
// type/length, payload) over valid/ready and drives GMII TX as preamble,
// SFD, frame bytes, zero padding up to the minimum length, CRC-32 FCS, and
// then holds the line idle for the inter-frame gap.
//
// Ports
//   i_tx_clk      transmit clock, everything on the rising edge
//   i_rst         synchronous active-high reset
//   i_valid       upstream byte valid
//   i_data[7:0]   upstream frame byte
//   i_last        final byte of the frame (qualified by i_valid)
//   o_ready       combinational: byte taken on an edge with i_valid & o_ready
//   o_tx_en       GMII TX_EN (registered)
//   o_tx_er       GMII TX_ER (registered)
//   o_txd[7:0]    GMII TXD (registered)
//   o_fsm_state   current state encoding
//   o_frame_done  one-cycle pulse alongside the last FCS byte of a good frame
module eth_tx_frame #(
  parameter int PRE_LEN = 7,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int IFG_LEN = 12
) (
  input  logic       i_tx_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_tx_en,
  output logic       o_tx_er,
  output logic [7:0] o_txd,
  output logic [2:0] o_fsm_state,
  output logic       o_frame_done
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    PRE  = 3'b001,
    SFD  = 3'b010,
    DATA = 3'b011,
    PAD  = 3'b100,
    FCS  = 3'b101,
    IFG  = 3'b110
  } state_e;

  localparam logic [7:0]  PRE_CNT = 8'(PRE_LEN);
  localparam logic [7:0]  IFG_CNT = 8'(IFG_LEN);
  localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
  localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

  state_e      state_q, state_d;
  logic [7:0]  phaseCnt_q, phaseCnt_d;
  logic [10:0] byteCnt_q, byteCnt_d;
  logic [31:0] crc_q, crc_d;
  logic        lastSeen_q, lastSeen_d;
  logic        abort_q, abort_d;
  logic        txEn_q, txEn_d;
  logic        txEr_q, txEr_d;
  logic [7:0]  txd_q, txd_d;
  logic        frameDone_q, frameDone_d;

  logic        accept;
  logic        underrun;
  logic        oversize;
  logic [31:0] crcInv;

  // One byte step of the reflected CRC-32 (0x04C11DB7 reversed = 0xEDB88320).
  function automatic logic [31:0] crcByte(input logic [31:0] crcIn, input logic [7:0] b);
    logic [31:0] c;
    c = crcIn ^ {24'h000000, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Upstream may push bytes from SFD onward until the i_last byte has been
  // taken; an aborted frame refuses everything until the gap starts.
  assign o_ready  = (state_q == SFD) ||
                    ((state_q == DATA) && !lastSeen_q && !abort_q);
  assign accept   = i_valid & o_ready;
  assign underrun = o_ready & ~i_valid;
  assign oversize = accept & (byteCnt_q == MAX_CNT);
  assign crcInv   = ~crc_q;

  assign o_tx_en      = txEn_q;
  assign o_tx_er      = txEr_q;
  assign o_txd        = txd_q;
  assign o_frame_done = frameDone_q;
  assign o_fsm_state  = state_q;

  // State register plus every datapath/output register; outputs change on
  // the same edge as the state so each GMII cycle matches o_fsm_state.
  always_ff @(posedge i_tx_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      phaseCnt_q  <= 8'd0;
      byteCnt_q   <= 11'd0;
      crc_q       <= 32'hFFFFFFFF;
      lastSeen_q  <= 1'b0;
      abort_q     <= 1'b0;
      txEn_q      <= 1'b0;
      txEr_q      <= 1'b0;
      txd_q       <= 8'h00;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phaseCnt_q  <= phaseCnt_d;
      byteCnt_q   <= byteCnt_d;
      crc_q       <= crc_d;
      lastSeen_q  <= lastSeen_d;
      abort_q     <= abort_d;
      txEn_q      <= txEn_d;
      txEr_q      <= txEr_d;
      txd_q       <= txd_d;
      frameDone_q <= frameDone_d;
    end
  end

  // Next-state logic. A fault (underrun or oversize) keeps the FSM in DATA
  // for one more cycle with abort_q set, which is the TX_ER cycle, and only
  // then moves to the gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_valid) state_d = PRE;
      PRE:  if (phaseCnt_q == PRE_CNT) state_d = SFD;
      SFD:  state_d = DATA;
      DATA: begin
        if (abort_q) begin
          state_d = IFG;
        end else if (lastSeen_q) begin
          state_d = (byteCnt_q < MIN_CNT) ? PAD : FCS;
        end
      end
      PAD:  if (byteCnt_q >= MIN_CNT) state_d = FCS;
      FCS:  if (phaseCnt_q == 8'd4) state_d = IFG;
      IFG:  if (phaseCnt_q == IFG_CNT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic: decides what the GMII registers carry during
  // the next cycle, together with the byte counter, CRC and phase counter.
  always_comb begin
    phaseCnt_d  = phaseCnt_q;
    byteCnt_d   = byteCnt_q;
    crc_d       = crc_q;
    lastSeen_d  = lastSeen_q;
    abort_d     = abort_q;
    txEn_d      = 1'b0;
    txEr_d      = 1'b0;
    txd_d       = 8'h00;
    frameDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        byteCnt_d  = 11'd0;
        crc_d      = 32'hFFFFFFFF;
        lastSeen_d = 1'b0;
        abort_d    = 1'b0;
        phaseCnt_d = 8'd0;
        if (i_valid) begin
          txEn_d     = 1'b1;
          txd_d      = 8'h55;
          phaseCnt_d = 8'd1;
        end
      end
      PRE: begin
        txEn_d    = 1'b1;
        byteCnt_d = 11'd0;
        crc_d     = 32'hFFFFFFFF;
        if (phaseCnt_q == PRE_CNT) begin
          txd_d = 8'hD5;
        end else begin
          txd_d      = 8'h55;
          phaseCnt_d = phaseCnt_q + 8'd1;
        end
      end
      SFD, DATA: begin
        if ((state_q == DATA) && abort_q) begin
          phaseCnt_d = 8'd1;
        end else if ((state_q == DATA) && lastSeen_q) begin
          txEn_d = 1'b1;
          if (byteCnt_q < MIN_CNT) begin
            crc_d     = crcByte(crc_q, 8'h00);
            byteCnt_d = byteCnt_q + 11'd1;
          end else begin
            txd_d      = crcInv[7:0];
            phaseCnt_d = 8'd1;
          end
        end else if (underrun || oversize) begin
          // The offending byte of an oversize frame is dropped here.
          txEn_d  = 1'b1;
          txEr_d  = 1'b1;
          abort_d = 1'b1;
        end else begin
          txEn_d     = 1'b1;
          txd_d      = i_data;
          crc_d      = crcByte(crc_q, i_data);
          byteCnt_d  = byteCnt_q + 11'd1;
          lastSeen_d = i_last;
        end
      end
      PAD: begin
        txEn_d = 1'b1;
        if (byteCnt_q < MIN_CNT) begin
          crc_d     = crcByte(crc_q, 8'h00);
          byteCnt_d = byteCnt_q + 11'd1;
        end else begin
          txd_d      = crcInv[7:0];
          phaseCnt_d = 8'd1;
        end
      end
      FCS: begin
        // phaseCnt_q selects which FCS byte goes out next (byte 0 was sent
        // on entry), least-significant byte first.
        if (phaseCnt_q != 8'd4) begin
          txEn_d      = 1'b1;
          txd_d       = crcInv[{phaseCnt_q[1:0], 3'b000} +: 8];
          frameDone_d = (phaseCnt_q == 8'd3);
          phaseCnt_d  = phaseCnt_q + 8'd1;
        end else begin
          phaseCnt_d = 8'd1;
        end
      end
      IFG: begin
        if (phaseCnt_q == IFG_CNT) begin
          phaseCnt_d = 8'd0;
        end else begin
          phaseCnt_d = phaseCnt_q + 8'd1;
        end
      end
      default: begin
        phaseCnt_d = 8'd0;
        byteCnt_d  = 11'd0;
        crc_d      = 32'hFFFFFFFF;
        lastSeen_d = 1'b0;
        abort_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_eth_tx_frame.sv
// tb_eth_tx_frame
// Scoreboard bench for eth_tx_frame. The stimulus side builds each frame
// from random bytes, works out the full GMII byte sequence the framer
// should produce and queues it; a monitor on the falling edge pops one
// entry for every o_tx_en cycle and compares.
module tb_eth_tx_frame;

  localparam int PRE_LEN = 7;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam int IFG_LEN = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;
  logic       txEn;
  logic       txEr;
  logic [7:0] txd;
  logic [2:0] fsmState;
  logic       done;

  typedef struct packed {
    logic       er;
    logic       done;
    logic [7:0] d;
  } exp_t;

  exp_t       sbQ[$];
  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  int         riseQ[$];
  int         lastRunLen = 0;
  bit         monActive = 1'b0;

  always #5 clk = ~clk;

  eth_tx_frame #(
    .PRE_LEN(PRE_LEN),
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN),
    .IFG_LEN(IFG_LEN)
  ) dut (
    .i_tx_clk    (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_data      (data),
    .i_last      (last),
    .o_ready     (ready),
    .o_tx_en     (txEn),
    .o_tx_er     (txEr),
    .o_txd       (txd),
    .o_fsm_state (fsmState),
    .o_frame_done(done)
  );

  // Single place where comparisons are counted and failures reported.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Textbook MSB-first CRC-32 on bit-reversed bytes, no final inversion.
  function automatic logic [31:0] refCrc(input logic [7:0] bytes[$]);
    logic [31:0] c;
    logic [7:0]  rb;
    c = 32'hFFFFFFFF;
    foreach (bytes[i]) begin
      for (int k = 0; k < 8; k++) rb[k] = bytes[i][7-k];
      c = c ^ {rb, 24'h000000};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  // Transmitted FCS value: complement of the bit-reversed register.
  function automatic logic [31:0] fcsOf(input logic [7:0] bytes[$]);
    logic [31:0] c;
    logic [31:0] r;
    c = refCrc(bytes);
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  // Monitor: consumes the scoreboard on every tx_en cycle, checks that the
  // line is quiet otherwise, and checks the FCS residue of completed frames.
  bit         prevEn = 1'b0;
  bit         sawDone = 1'b0;
  int         runLen = 0;
  logic [7:0] runBytes[$];
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] body[$];
    cycle++;
    if (monActive) begin
      if (txEn === 1'b1) begin
        if (!prevEn) begin
          riseQ.push_back(cycle);
          runLen = 0;
          sawDone = 1'b0;
          runBytes.delete();
        end
        runLen++;
        runBytes.push_back(txd);
        if (done === 1'b1) sawDone = 1'b1;
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedTxEn", {22'd0, txEr, done, txd}, 32'hFFFFFFFF);
        end else begin
          e = sbQ.pop_front();
          checkOutput("gmiiByte", {22'd0, txEr, done, txd}, {22'd0, e.er, e.done, e.d});
        end
      end else begin
        checkOutput("idleLine", {22'd0, txEr, done, txd}, 32'd0);
        if (prevEn) begin
          lastRunLen = runLen;
          if (sawDone) begin
            body.delete();
            for (int i = PRE_LEN + 1; i < runBytes.size(); i++) body.push_back(runBytes[i]);
            checkOutput("fcsResidue", refCrc(body), 32'hC704DD7B);
          end
        end
      end
      prevEn = (txEn === 1'b1);
    end
  end

  // Sends one frame of n random bytes, delivering `accepts` of them.
  // Good frame: withLast and accepts == n <= MAX_LEN. Anything else ends in
  // a TX_ER cycle, unless noTail (frame cut by reset) suppresses the tail.
  task automatic applyStimulus(input int n, input bit withLast, input int accepts,
                               input int expectWait, input bit keepValid, input bit noTail);
    logic [7:0] bq[$];
    logic [7:0] padded[$];
    logic [31:0] fcs;
    int idx;
    int waited;
    int stalls;
    int guard;
    int emitted;
    bit good;
    bit rdy;
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    good = withLast && (accepts == n) && (n <= MAX_LEN);
    emitted = (accepts > MAX_LEN) ? MAX_LEN : accepts;
    for (int i = 0; i < PRE_LEN; i++) sbQ.push_back('{er: 1'b0, done: 1'b0, d: 8'h55});
    sbQ.push_back('{er: 1'b0, done: 1'b0, d: 8'hD5});
    for (int i = 0; i < emitted; i++) sbQ.push_back('{er: 1'b0, done: 1'b0, d: bq[i]});
    if (good) begin
      for (int i = 0; i < n; i++) padded.push_back(bq[i]);
      while (padded.size() < MIN_LEN) padded.push_back(8'h00);
      for (int i = n; i < MIN_LEN; i++) sbQ.push_back('{er: 1'b0, done: 1'b0, d: 8'h00});
      fcs = fcsOf(padded);
      for (int i = 0; i < 4; i++) sbQ.push_back('{er: 1'b0, done: (i == 3), d: fcs[8*i +: 8]});
    end else if (!noTail) begin
      sbQ.push_back('{er: 1'b1, done: 1'b0, d: 8'h00});
    end

    idx = 0; waited = 0; stalls = 0; guard = 0;
    valid = 1'b1;
    data = bq[0];
    last = withLast && (n == 1);
    while (idx < accepts && guard < 4000) begin
      @(negedge clk);
      rdy = (ready === 1'b1);
      @(posedge clk);
      #1;
      guard++;
      if (rdy) begin
        idx++;
        if (idx < accepts) begin
          data = bq[idx];
          last = withLast && (idx == n - 1);
        end
      end else if (idx == 0) begin
        waited++;
      end else begin
        stalls++;
      end
    end
    checkOutput("bytesAccepted", idx, accepts);
    checkOutput("readyWait", waited, expectWait);
    checkOutput("readyStall", stalls, 0);
    if (!keepValid) begin
      valid = 1'b0;
      last = 1'b0;
    end
  endtask

  // Waits until the scoreboard has drained and the framer is back in IDLE,
  // then lines up just after a rising edge.
  task automatic waitIdle();
    int  n;
    bit  ok;
    ok = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && txEn === 1'b0 && fsmState === 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("idleTimeout", sbQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic int goodLen(input int n);
    return PRE_LEN + 1 + ((n < MIN_LEN) ? MIN_LEN : n) + 4;
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    valid = 1'b0;
    data = 8'h00;
    last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstTxEn", txEn, 0);
    checkOutput("rstTxEr", txEr, 0);
    checkOutput("rstTxd", txd, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstReady", ready, 0);
    checkOutput("rstState", fsmState, 0);
    rst = 1'b0;
    monActive = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] 64-byte frame");
    applyStimulus(64, 1'b1, 64, 8, 1'b0, 1'b0);
    waitIdle();
    checkOutput("txEnLen64", lastRunLen, goodLen(64));

    $display("[TB] 14-byte frame with padding");
    applyStimulus(14, 1'b1, 14, 8, 1'b0, 1'b0);
    waitIdle();
    checkOutput("txEnLen14", lastRunLen, 72);

    $display("[TB] random frames");
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 130);
      applyStimulus(n, 1'b1, n, 8, 1'b0, 1'b0);
      waitIdle();
      checkOutput("txEnLenRand", lastRunLen, goodLen(n));
    end

    $display("[TB] underrun after 20 bytes");
    applyStimulus(64, 1'b0, 20, 8, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("underrunErCycle", {30'd0, txEn, txEr}, 32'd3);
    @(negedge clk);
    checkOutput("underrunIfgState", fsmState, 3'b110);
    checkOutput("underrunIfgTxEn", txEn, 0);
    waitIdle();
    checkOutput("txEnLenUnderrun", lastRunLen, PRE_LEN + 1 + 20 + 1);

    $display("[TB] oversize frame");
    applyStimulus(MAX_LEN + 1, 1'b0, MAX_LEN + 1, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("oversizeErCycle", {30'd0, txEn, txEr}, 32'd3);
    @(negedge clk);
    checkOutput("oversizeIfgState", fsmState, 3'b110);
    waitIdle();
    checkOutput("txEnLenOversize", lastRunLen, PRE_LEN + 1 + MAX_LEN + 1);

    $display("[TB] back-to-back 60-byte frames");
    applyStimulus(60, 1'b1, 60, 8, 1'b1, 1'b0);
    applyStimulus(60, 1'b1, 60, 1 + 4 + IFG_LEN + 1 + PRE_LEN, 1'b0, 1'b0);
    waitIdle();
    checkOutput("txEnLenB2b", lastRunLen, 72);
    if (riseQ.size() >= 2) begin
      checkOutput("b2bSpacing", riseQ[riseQ.size()-1] - riseQ[riseQ.size()-2],
                  8 + MIN_LEN + 4 + IFG_LEN + 1);
    end else begin
      checkOutput("b2bRiseCount", riseQ.size(), 2);
    end

    $display("[TB] reset during DATA");
    applyStimulus(40, 1'b0, 10, 8, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midRstTxEn", txEn, 0);
    checkOutput("midRstState", fsmState, 0);
    checkOutput("midRstReady", ready, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstQueue", sbQ.size(), 0);
    sbQ.delete();
    @(posedge clk);
    #1;
    applyStimulus(64, 1'b1, 64, 8, 1'b0, 1'b0);
    waitIdle();
    checkOutput("txEnLenAfterRst", lastRunLen, goodLen(64));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Hard stop in case something upstream of the bounded waits hangs.
  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
